bcd_digit_streamer: RTL and testbench
=====================================

Name: bcd_digit_streamer

Overview:
Reads a multi-digit packed BCD value, such as the outputs of the cascaded BCD counter digits, and streams it out as ASCII characters for the OLED text renderer. It applies leading-zero blanking and optional decimal-point insertion, and flags out-of-range digits. It sits between the frequency-count latch and the character/glyph pipeline. A valid/ready handshake applies backpressure.

Parameters:
DIGITS, 6, number of BCD digits in bcd_in (2..8)
BLANK_CHAR, 8'h20, character emitted for a blanked leading zero
ERR_CHAR, 8'h3F, character emitted for a digit nibble > 9

Ports:
clk_in  input  1  clock
reset_in  input  1  asynchronous reset, active-high
start_in  input  1  request to stream; sampled only in IDLE
bcd_in  input  4*DIGITS  packed BCD, digit i = bcd_in[4i+3:4i], digit 0 = units
dp_en_in  input  1  enable decimal point
dp_pos_in  input  3  number of fractional digits (point placed after digit dp_pos_in)
busy_out  output  1  high from start acceptance until final transfer
char_out  output  8  ASCII character
char_valid_out  output  1  char_out valid
char_ready_in  input  1  consumer accepts char_out
char_last_out  output  1  marks final character of the frame

Behaviour:
- Reset, asynchronous: state IDLE; busy_out=0, char_valid_out=0, char_last_out=0, char_out=8'h00; snapshot registers cleared.
- States: IDLE -> EMIT_DIGIT <-> EMIT_DP -> IDLE.
- IDLE: on a clk_in edge with start_in=1:
  - capture bcd_in, dp_en_in and dp_pos_in into snapshot registers;
  - set digit index = DIGITS-1;
  - enter EMIT_DIGIT;
  - assert busy_out and char_valid_out with the first character in the next cycle (1-cycle latency).
  - Later changes to inputs do not affect the frame.
- Effective point: dp active iff dp_en=1 and 0 < dp_pos < DIGITS. dp_pos=0 or dp_pos>=DIGITS means no point.
- Keep-position K = dp_pos if the point is active, else 0.
- Digit i output:
  - nibble>9 -> ERR_CHAR;
  - else if nibble==0 and i>K and all higher digits are zero -> BLANK_CHAR;
  - else 8'h30+nibble.
  - A nibble>9 counts as non-zero for blanking of lower digits.
- Transfer occurs on a clk_in edge with char_valid_out=1 and char_ready_in=1.
- While valid and not ready, char_out and char_last_out hold stable; no drop, no duplicate.
- After a digit i transfer:
  - if dp active and i==dp_pos -> EMIT_DP, presenting 8'h2E ('.');
  - else if i==0 -> IDLE;
  - else i-1 in EMIT_DIGIT.
- After a '.' transfer -> EMIT_DIGIT with i=dp_pos-1.
- Back-to-back: next character valid in the cycle after a transfer, no bubbles.
- Frame length: DIGITS characters, plus 1 if the point is active.
- char_last_out=1 only with digit 0.
- Final transfer: next cycle busy_out=0, char_valid_out=0, char_last_out=0; char_out holds its last value.
- start_in while busy is ignored (not queued).
- A new start is accepted in the cycle after IDLE is reached.
- Reset mid-frame aborts immediately with no partial completion; the next start after reset release streams a full frame.
- char_ready_in high while char_valid_out=0 has no effect.

Test Plan:
1. DIGITS=6, bcd_in=24'h001234, dp_en=0, ready tied 1, start pulse -> 6 consecutive chars 20 20 31 32 33 34 on cycles 1..6; last only on 34; busy_out falls cycle 7.
2. bcd_in=24'h000000, dp_en=0 -> 20 20 20 20 20 30; last on 30.
3. bcd_in=24'h000005, dp_en=1, dp_pos=3 -> 20 20 30 2E 30 30 35 (7 chars); dp_pos=6 with same value -> treated as no point, 20 20 20 20 20 35.
4. bcd_in=24'h987654, pseudo-random ready stall pattern (~50%) -> 39 38 37 36 35 34 in order; char_out constant across every stall cycle; exactly 6 transfers.
5. bcd_in=24'h00A010 -> 20 20 3F 30 31 30; second start_in pulse during frame -> ignored, exactly one frame emitted.
6. Assert reset_in asynchronously after 3rd transfer -> valid/busy/last drop without a clock edge; after release, start with 24'h000042 -> 20 20 20 20 34 32.

Source files
------------

// File: rtl/bcd_digit_streamer.sv
// bcd_digit_streamer: streams a packed BCD value as ASCII characters with
// leading-zero blanking, optional decimal point and a valid/ready handshake.
module bcd_digit_streamer #(
    parameter int              DIGITS     = 6,
    parameter logic [7:0]      BLANK_CHAR = 8'h20,
    parameter logic [7:0]      ERR_CHAR   = 8'h3F
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  dp_en_in,
    input  logic [2:0]            dp_pos_in,
    output logic                  busy_out,
    output logic [7:0]            char_out,
    output logic                  char_valid_out,
    input  logic                  char_ready_in,
    output logic                  char_last_out
);
    typedef enum logic [1:0] {IDLE, EMIT_DIGIT, EMIT_DP} state_t;

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  dp_en_q, dp_en_d;
    logic [2:0]            dp_pos_q, dp_pos_d;
    logic [7:0]            char_q, char_d;
    logic                  dp_act, xfer;

    function automatic logic dp_active(input logic dpe, input logic [2:0] dpp);
        return dpe && dpp != 3'd0 && int'(dpp) < DIGITS;
    endfunction

    // A nibble > 9 counts as non-zero, so it stops blanking of lower digits.
    function automatic logic [7:0] digit_char(input logic [4*DIGITS-1:0] b, input logic dpe,
                                              input logic [2:0] dpp, input logic [2:0] i);
        logic [3:0] nib;
        logic       hz;
        int         k;
        k   = dp_active(dpe, dpp) ? int'(dpp) : 0;
        nib = b[4*int'(i) +: 4];
        hz  = 1'b1;
        for (int j = 0; j < DIGITS; j++)
            if (j > int'(i) && b[4*j +: 4] != 4'd0) hz = 1'b0;
        return nib > 4'd9 ? ERR_CHAR :
               (nib == 4'd0 && int'(i) > k && hz) ? BLANK_CHAR : 8'h30 + {4'd0, nib};
    endfunction

    assign dp_act         = dp_active(dp_en_q, dp_pos_q);
    assign busy_out       = state_q != IDLE;
    assign char_valid_out = state_q != IDLE;
    assign char_last_out  = state_q == EMIT_DIGIT && idx_q == 3'd0;
    assign char_out       = char_q;
    assign xfer           = char_valid_out && char_ready_in;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            bcd_q    <= '0;
            dp_en_q  <= 1'b0;
            dp_pos_q <= 3'd0;
            char_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bcd_q    <= bcd_d;
            dp_en_q  <= dp_en_d;
            dp_pos_q <= dp_pos_d;
            char_q   <= char_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bcd_d    = bcd_q;
        dp_en_d  = dp_en_q;
        dp_pos_d = dp_pos_q;
        char_d   = char_q;
        case (state_q)
            IDLE: if (start_in) begin
                state_d  = EMIT_DIGIT;
                idx_d    = 3'(DIGITS-1);
                bcd_d    = bcd_in;
                dp_en_d  = dp_en_in;
                dp_pos_d = dp_pos_in;
                char_d   = digit_char(bcd_in, dp_en_in, dp_pos_in, 3'(DIGITS-1));
            end
            EMIT_DIGIT: if (xfer) begin
                if (dp_act && idx_q == dp_pos_q) begin
                    state_d = EMIT_DP;
                    char_d  = 8'h2E;
                end else if (idx_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    idx_d  = idx_q - 3'd1;
                    char_d = digit_char(bcd_q, dp_en_q, dp_pos_q, idx_q - 3'd1);
                end
            end
            EMIT_DP: if (xfer) begin
                state_d = EMIT_DIGIT;
                idx_d   = dp_pos_q - 3'd1;
                char_d  = digit_char(bcd_q, dp_en_q, dp_pos_q, dp_pos_q - 3'd1);
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bcd_digit_streamer.sv
// tb_bcd_digit_streamer: directed frames with hand-computed character streams.
module tb_bcd_digit_streamer;
    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        start_in = 1'b0;
    logic [23:0] bcd_in = '0;
    logic        dp_en_in = 1'b0;
    logic [2:0]  dp_pos_in = 3'd0;
    logic        busy_out, char_valid_out, char_ready_in, char_last_out;
    logic [7:0]  char_out;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] pat = 32'hB4E2_5A39;

    bcd_digit_streamer #(.DIGITS(6)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .bcd_in(bcd_in),
        .dp_en_in(dp_en_in), .dp_pos_in(dp_pos_in), .busy_out(busy_out),
        .char_out(char_out), .char_valid_out(char_valid_out),
        .char_ready_in(char_ready_in), .char_last_out(char_last_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // exp_s holds the n expected characters, first character in the highest byte.
    task automatic run_frame(input string tag, input logic [23:0] bcd, input logic dpe,
                             input logic [2:0] dpp, input logic [63:0] exp_s, input int n,
                             input logic stall, input logic restart);
        int         k, cyc;
        logic       held;
        logic [7:0] hold_c, e;
        @(negedge clk_in);
        bcd_in = bcd; dp_en_in = dpe; dp_pos_in = dpp; start_in = 1'b1; char_ready_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0; bcd_in = 24'h999999; dp_en_in = ~dpe;
        chk({tag, " busy"}, 32'(busy_out), 32'd1);
        k = 0; cyc = 0; held = 1'b0; hold_c = 8'h00;
        while (k < n && cyc < 200) begin
            char_ready_in = stall ? pat[cyc[4:0]] : 1'b1;
            start_in = restart && cyc == 2;
            chk({tag, " valid"}, 32'(char_valid_out), 32'd1);
            if (held) chk({tag, " hold"}, 32'(char_out), 32'(hold_c));
            if (char_ready_in) begin
                e = exp_s[8*(n-1-k) +: 8];
                chk($sformatf("%s char%0d", tag, k), 32'(char_out), 32'(e));
                chk($sformatf("%s last%0d", tag, k), 32'(char_last_out), 32'(k == n-1));
                k++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                hold_c = char_out;
            end
            cyc++;
            @(negedge clk_in);
        end
        start_in = 1'b0;
        if (k < n) chk({tag, " timeout"}, 32'(k), 32'(n));
        chk({tag, " end busy"}, 32'(busy_out), 32'd0);
        chk({tag, " end valid"}, 32'(char_valid_out), 32'd0);
        chk({tag, " end last"}, 32'(char_last_out), 32'd0);
        chk({tag, " end char"}, 32'(char_out), 32'(exp_s[7:0]));
        repeat (3) begin
            @(negedge clk_in);
            chk({tag, " idle"}, 32'(char_valid_out), 32'd0);
        end
    endtask

    initial begin
        char_ready_in = 1'b1;
        #1;
        chk("rst busy", 32'(busy_out), 32'd0);
        chk("rst valid", 32'(char_valid_out), 32'd0);
        chk("rst last", 32'(char_last_out), 32'd0);
        chk("rst char", 32'(char_out), 32'd0);
        @(negedge clk_in);
        reset_in = 1'b0;
        run_frame("t1", 24'h001234, 1'b0, 3'd0, 64'h202031323334, 6, 1'b0, 1'b0);
        run_frame("t2", 24'h000000, 1'b0, 3'd0, 64'h202020202030, 6, 1'b0, 1'b0);
        run_frame("t3a", 24'h000005, 1'b1, 3'd3, 64'h2020302E303035, 7, 1'b0, 1'b0);
        run_frame("t3b", 24'h000005, 1'b1, 3'd6, 64'h202020202035, 6, 1'b0, 1'b0);
        run_frame("t3c", 24'h000005, 1'b1, 3'd0, 64'h202020202035, 6, 1'b0, 1'b0);
        run_frame("t4", 24'h987654, 1'b0, 3'd0, 64'h393837363534, 6, 1'b1, 1'b0);
        run_frame("t5", 24'h00A010, 1'b0, 3'd0, 64'h20203F303130, 6, 1'b0, 1'b1);
        run_frame("t7", 24'h120034, 1'b1, 3'd1, 64'h31323030332E34, 7, 1'b1, 1'b0);
        @(negedge clk_in);
        bcd_in = 24'h987654; dp_en_in = 1'b0; start_in = 1'b1; char_ready_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #2 reset_in = 1'b1;
        #1;
        chk("t6 abort busy", 32'(busy_out), 32'd0);
        chk("t6 abort valid", 32'(char_valid_out), 32'd0);
        chk("t6 abort last", 32'(char_last_out), 32'd0);
        chk("t6 abort char", 32'(char_out), 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b0;
        run_frame("t6", 24'h000042, 1'b0, 3'd0, 64'h202020203432, 6, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
